// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bubble encoding, opcodes and small decode helpers
// used by the fetch, decode and stall-control stages.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hFC00_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    PC_SEL_BRANCH = 2'd0,
    PC_SEL_JUMP   = 2'd1,
    PC_SEL_SEQ    = 2'd2,
    PC_SEL_HOLD   = 2'd3
  } pc_sel_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  // Pseudo-direct jump: upper nibble comes from the already-incremented PC.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == CNT_MAX) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface fetch_stage_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// Generic 32+32-bit pipeline register with load enable, synchronous flush to a
// bubble and synchronous active-low reset. Flush takes priority over a hold.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'hFC00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4
);

  logic [31:0] instr_d;
  logic [31:0] instr_q;
  logic [31:0] pc4_d;
  logic [31:0] pc4_q;

  // Next-state selection: flush, load or hold.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0000_0000;
    end else if (en) begin
      instr_d = in_instr;
      pc4_d   = in_pc4;
    end else begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
    end
  end

  // Register update with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign out_instr = instr_q;
  assign out_pc4   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (branch / jump /
// sequential / hold), IF/ID pipeline register and saturating event counters.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pcenable,
  input  logic                 idifenable,
  input  logic                 ifidNOP,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  fetch_stage_if.master        imem,
  output logic [31:0]          instructionFetch,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc4,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          flush_cnt
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic [31:0] pc4_s;
  logic [31:0] jtgt_s;
  logic [31:0] instr_s;
  logic        fetch_is_j_s;
  logic        ifid_flush_s;
  pc_sel_e     pc_sel_s;
  logic [15:0] stall_cnt_d;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_d;
  logic [15:0] flush_cnt_q;

  assign instr_s          = imem.imem_rdata;
  assign imem.imem_addr   = pc_q;
  assign instructionFetch = instr_s;

  assign pc4_s        = pc_q + 32'd4;
  assign jtgt_s       = jump_target(pc4_s, instr_s);
  assign fetch_is_j_s = (opcode_of(instr_s) == OP_J);
  assign ifid_flush_s = branch_taken | ifidNOP;

  // Next-PC source in priority order; a taken branch overrides a stall.
  always_comb begin
    pc_sel_s = PC_SEL_HOLD;
    if (branch_taken) begin
      pc_sel_s = PC_SEL_BRANCH;
    end else if (pcenable && fetch_is_j_s) begin
      pc_sel_s = PC_SEL_JUMP;
    end else if (pcenable) begin
      pc_sel_s = PC_SEL_SEQ;
    end else begin
      pc_sel_s = PC_SEL_HOLD;
    end
  end

  // Next-PC mux; branch targets are word-aligned by clearing the low bits.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel_s)
      PC_SEL_BRANCH: pc_d = {branch_target[31:2], 2'b00};
      PC_SEL_JUMP:   pc_d = jtgt_s;
      PC_SEL_SEQ:    pc_d = pc4_s;
      PC_SEL_HOLD:   pc_d = pc_q;
      default:       pc_d = pc_q;
    endcase
  end

  // Saturating counters: a branch cycle is a flush, never a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (branch_taken) begin
      flush_cnt_d = sat_inc16(flush_cnt_q);
    end else if (!pcenable) begin
      stall_cnt_d = sat_inc16(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
    end
  end

  // PC and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (idifenable),
    .flush     (ifid_flush_s),
    .in_instr  (instr_s),
    .in_pc4    (pc4_s),
    .out_instr (if_id_instr),
    .out_pc4   (if_id_pc4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a cycle-level
// behavioural model of the PC, IF/ID register and counters.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcenable;
  logic        idifenable;
  logic        ifidNOP;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instructionFetch;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  fetch_stage_if imem ();

  fetch_stage #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pcenable         (pcenable),
    .idifenable       (idifenable),
    .ifidNOP          (ifidNOP),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem             (imem.master),
    .instructionFetch (instructionFetch),
    .if_id_instr      (if_id_instr),
    .if_id_pc4        (if_id_pc4),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: 256-word table, optionally overridden by a directed word.
  logic [31:0] mem [0:255];
  logic        ovr_en;
  logic [31:0] ovr_word;
  assign imem.imem_rdata = ovr_en ? ovr_word : mem[imem.imem_addr[9:2]];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  int          m_stall;
  int          m_flush;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] pc);
    return ovr_en ? ovr_word : mem[pc[9:2]];
  endfunction

  // One clock: predict from the rules, advance, then compare every output.
  task automatic step();
    logic [31:0] w;
    logic [31:0] seq;
    logic [31:0] n_pc;
    logic [31:0] n_instr;
    logic [31:0] n_pc4;
    int          n_stall;
    int          n_flush;
    w       = model_word(m_pc);
    seq     = m_pc + 32'd4;
    n_pc    = m_pc;
    n_instr = m_instr;
    n_pc4   = m_pc4;
    n_stall = m_stall;
    n_flush = m_flush;
    if (!rst_n) begin
      n_pc = RST_PC; n_instr = NOP; n_pc4 = 32'd0; n_stall = 0; n_flush = 0;
    end else begin
      if (branch_taken)
        n_pc = branch_target - (branch_target % 32'd4);
      else if (pcenable && (w >> 26) == 32'd2)
        n_pc = (seq & 32'hF000_0000) + ((w & 32'h03FF_FFFF) * 32'd4);
      else if (pcenable)
        n_pc = seq;
      if (branch_taken || ifidNOP) begin
        n_instr = NOP; n_pc4 = 32'd0;
      end else if (idifenable) begin
        n_instr = w; n_pc4 = seq;
      end
      if (branch_taken && m_flush < 65535) n_flush = m_flush + 1;
      if (!branch_taken && !pcenable && m_stall < 65535) n_stall = m_stall + 1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_stall = n_stall; m_flush = n_flush;
    check_eq("imem_addr", imem.imem_addr, m_pc);
    check_eq("instructionFetch", instructionFetch, model_word(m_pc));
    check_eq("if_id_instr", if_id_instr, m_instr);
    check_eq("if_id_pc4", if_id_pc4, m_pc4);
    check_eq("stall_cnt", {16'd0, stall_cnt}, m_stall[31:0]);
    check_eq("flush_cnt", {16'd0, flush_cnt}, m_flush[31:0]);
  endtask

  task automatic drive(input logic rst, input logic pcen, input logic idif,
                       input logic nop, input logic bt, input logic [31:0] tgt);
    rst_n = rst; pcenable = pcen; idifenable = idif; ifidNOP = nop;
    branch_taken = bt; branch_target = tgt;
  endtask

  initial begin
    logic [31:0] w;
    int          flush_before;
    int          stall_before;

    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(0, 5) == 0) w[31:26] = 6'b000010;
      if (i < 4 && w[31:26] == 6'b000010) w[31:26] = 6'b000000;
      mem[i] = w;
    end
    ovr_en = 1'b0; ovr_word = 32'd0;
    m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_stall = 0; m_flush = 0;

    // Reset held for two edges
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    step();
    check_eq("reset_pc", imem.imem_addr, 32'h0000_0100);
    check_eq("reset_ifid", if_id_instr, 32'hFC00_0000);

    // Sequential fetch from pc 0
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq("seq_addr", imem.imem_addr, 32'd4 * i);
      check_eq("seq_pc4", if_id_pc4, 32'd4 * i);
    end

    // Three-cycle stall at pc 0x20
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20);
    step();
    stall_before = m_stall;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) step();
    check_eq("stall_pc", imem.imem_addr, 32'h20);
    check_eq("stall_cnt3", {16'd0, stall_cnt}, stall_before[31:0] + 32'd3);

    // Jump fetched with ifidNOP
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0040);
    step();
    ovr_en = 1'b1; ovr_word = 32'h0800_0010;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step();
    check_eq("jump_pc", imem.imem_addr, 32'h1000_0040);
    check_eq("jump_ifid", if_id_instr, 32'hFC00_0000);

    // Branch beats stall and jump, misaligned target
    flush_before = m_flush;
    stall_before = m_stall;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h203);
    step();
    ovr_en = 1'b0;
    check_eq("br_pc", imem.imem_addr, 32'h200);
    check_eq("br_ifid", if_id_instr, 32'hFC00_0000);
    check_eq("br_flush", {16'd0, flush_cnt}, flush_before[31:0] + 32'd1);
    check_eq("br_stall", {16'd0, stall_cnt}, stall_before[31:0]);

    // Random control traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom);
      step();
    end

    // Stall counter saturation, then reset during stall and branch
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 65540; i++) step();
    check_eq("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400);
    step();
    check_eq("rst_mid_pc", imem.imem_addr, 32'h0000_0100);
    check_eq("rst_mid_ifid", if_id_instr, 32'hFC00_0000);
    check_eq("rst_mid_pc4", if_id_pc4, 32'd0);
    check_eq("rst_mid_stall", {16'd0, stall_cnt}, 32'd0);
    check_eq("rst_mid_flush", {16'd0, flush_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register. Holds the PC, drives the instruction-memory address, and resolves `j` redirects in-stage. Takes taken-branch redirects from EX. Obeys the stall/flush controls (`pcenable`, `idifenable`, `ifidNOP`) from the hazard/stall controller, and feeds the decode stage and the controller's fetch-instruction input.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `NOP_INSTR`, 32'hFC00_0000, bubble encoding (opcode 6'b111111).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `pcenable`  in  1  1 = PC may advance; 0 = hold PC (data-hazard stall).
- `idifenable`  in  1  1 = IF/ID register may load; 0 = hold.
- `ifidNOP`  in  1  1 = load `NOP_INSTR` into IF/ID this cycle.
- `branch_taken`  in  1  EX stage resolved beq/bne as taken.
- `branch_target`  in  32  redirect address from EX.
- `imem_addr`  out  32  equals current PC, combinational.
- `imem_rdata`  in  32  instruction at `imem_addr`; asynchronous read, valid in the same cycle.
- `instructionFetch`  out  32  equals `imem_rdata`, combinational; goes to the stall controller.
- `if_id_instr`  out  32  IF/ID instruction register.
- `if_id_pc4`  out  32  IF/ID copy of PC+4.
- `stall_cnt`  out  16  saturating count of stalled fetch cycles.
- `flush_cnt`  out  16  saturating count of branch flushes.

## Operation
Internal values:
- `pc4` = pc + 4, wraps modulo 2^32.
- `jtgt` = {pc4[31:28], imem_rdata[25:0], 2'b00}.
- `fetch_is_j` = (imem_rdata[31:26] == 6'b000010).

Next-PC selection, in priority order:
1. `branch_taken`: pc <= {branch_target[31:2], 2'b00}. Overrides `pcenable`.
2. `pcenable` and `fetch_is_j`: pc <= jtgt.
3. `pcenable`: pc <= pc4.
4. Otherwise: pc holds.

IF/ID register, in priority order:
1. `branch_taken` or `ifidNOP`: if_id_instr <= NOP_INSTR and if_id_pc4 <= 0. This applies even if `idifenable` = 0, because a flush beats a hold.
2. `idifenable`: if_id_instr <= imem_rdata and if_id_pc4 <= pc4.
3. Otherwise: hold.

Jump handling:
- A fetched `j` redirects the PC in the same cycle it is fetched.
- The `j` word itself enters IF/ID unless `ifidNOP` is asserted; the controller normally does assert it, so the `j` becomes a bubble.

Counters:
- `stall_cnt` increments when `pcenable` = 0 and `branch_taken` = 0.
- `flush_cnt` increments when `branch_taken` = 1.
- Both saturate at 16'hFFFF and never wrap.

Boundary cases:
- `branch_taken` together with `fetch_is_j`: the branch wins and the `j` is discarded.
- `branch_taken` together with `pcenable` = 0: the branch wins and the stall is dropped for that cycle.
- `pcenable` = 0 with `idifenable` = 1: IF/ID reloads the same PC's word. This is legal and harmless.
- Misaligned `branch_target`: the low 2 bits are forced to 0.

## Timing
- Reset (`rst_n` = 0 at an edge): pc = `RESET_PC`, if_id_instr = `NOP_INSTR`, if_id_pc4 = 0, `stall_cnt` = 0, `flush_cnt` = 0. Reset beats every other input, including mid-stall or mid-flush.
- `imem_addr` and `instructionFetch` follow pc / `imem_rdata` combinationally; there is no added latency.
- Fetch to decode latency: 1 cycle. The word fetched at edge N is on `if_id_instr` after edge N+1.
- Taken-branch redirect: the target is fetched in the cycle after the edge where `branch_taken` was sampled high.
- Jump redirect: the target is fetched in the cycle after the `j` is fetched (1 bubble when the controller asserts `ifidNOP`).
- Control inputs are sampled only at the rising edge; glitches between edges have no effect.

## Structure
- Shared package `pipeline_pkg` holds `NOP_INSTR` and the opcode constants `OP_RTYPE`, `OP_J`, `OP_BEQ`, `OP_BNE`, `OP_NOP`. The decoder and stall controller use the same package.
- One sub-module, `if_id_reg`: 32+32-bit register with enable, synchronous flush-to-NOP, and synchronous active-low reset. It is reused for the later ID/EX and EX/MEM registers.
- Next-PC mux and counters live in `fetch_stage` itself.

## Test plan
- Reset: hold `rst_n` = 0 for 2 edges with `RESET_PC` = 32'h100 -> imem_addr = 32'h100, if_id_instr = 32'hFC00_0000, both counters = 0.
- Sequential fetch: all controls inactive, 3 edges from pc 0 -> imem_addr steps 4, 8, 12, and if_id_pc4 tracks each +4.
- Stall: `pcenable` = 0 and `idifenable` = 0 for 3 edges at pc 32'h20 -> pc and IF/ID hold, `stall_cnt` = 3.
- Jump: at pc 32'h1000_0040, imem_rdata = 32'h0800_0010 with `ifidNOP` = 1 -> next pc = 32'h1000_0040, if_id_instr = NOP.
- Branch priority: `branch_taken` = 1, `branch_target` = 32'h203, `pcenable` = 0, fetched word is a `j` -> pc = 32'h200, IF/ID = NOP, `flush_cnt` = 1, `stall_cnt` unchanged.
- Saturation and mid-operation reset: force `stall_cnt` to 16'hFFFF, stall again -> stays 16'hFFFF; then drop `rst_n` during the stall -> all outputs return to reset values at the next edge.
